lorenz_step_sequencer: RTL and testbench

LORENZ_STEP_SEQUENCER -- requirements
Module: lorenz_step_sequencer

---
 rtl/lorenz_step_sequencer.sv | 149 ++++++++++++++
 tb/tb_lorenz_step_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lorenz_step_sequencer.sv
// Lorenz attractor Euler integrator in signed 7.20 fixed point. One shared multiplier is
// time-multiplexed over four product states; the state vector only changes in UPD.
module lorenz_step_sequencer #(
  parameter int WIDTH    = 27,
  parameter int DT_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             init,
  input  logic             run,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic             busy,
  output logic             ovf,
  output logic [31:0]      step_count
);
  localparam int FRAC = 20;
  localparam int PW   = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] X_RST     = WIDTH'(-1048576);
  localparam logic signed [WIDTH-1:0] Y_RST     = WIDTH'(104857);
  localparam logic signed [WIDTH-1:0] Z_RST     = WIDTH'(26214400);
  localparam logic signed [WIDTH-1:0] SIGMA_RST = WIDTH'(10485760);
  localparam logic signed [WIDTH-1:0] BETA_RST  = WIDTH'(2796202);
  localparam logic signed [WIDTH-1:0] RHO_RST   = WIDTH'(29360128);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, UPD, EMIT} state_t;
  state_t state, state_nx;

  logic signed [WIDTH-1:0] xs, ys, zs;
  logic signed [WIDTH-1:0] x0, y0, z0, sigma, beta, rho;
  logic signed [WIDTH-1:0] p0, p1, p2, p3;

  logic signed [WIDTH-1:0] op_a, op_b, rho_mz;
  logic signed [PW-1:0]    a_ext, b_ext, prod;
  logic signed [WIDTH-1:0] prod_fmt;
  logic                    prod_ovf;
  logic                    unused_prod_lsbs;

  // Operands come straight from the state registers, which hold still until UPD,
  // so every product of a step sees the state as it was at MUL0.
  assign rho_mz = rho - zs;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      MUL0: begin op_a = sigma  >>> DT_SHIFT; op_b = ys - xs; end
      MUL1: begin op_a = rho_mz >>> DT_SHIFT; op_b = xs;      end
      MUL2: begin op_a = xs     >>> DT_SHIFT; op_b = ys;      end
      MUL3: begin op_a = zs     >>> DT_SHIFT; op_b = beta;    end
      default: ;
    endcase
  end

  assign a_ext = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a});
  assign b_ext = $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
  assign prod  = a_ext * b_ext;

  // Keep the sign and the bits at the 7.20 point; any integer bit that disagrees with
  // the sign is a lost magnitude and raises the sticky flag.
  assign prod_fmt         = {prod[PW-1], prod[FRAC+WIDTH-2:FRAC]};
  assign prod_ovf         = prod[PW-2:FRAC+WIDTH-1] != {(PW-WIDTH-FRAC){prod[PW-1]}};
  assign unused_prod_lsbs = ^prod[FRAC-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run && !init) state_nx = MUL0;
      MUL0:    state_nx = MUL1;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = MUL3;
      MUL3:    state_nx = UPD;
      UPD:     state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = run ? MUL0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      xs         <= X_RST;
      ys         <= Y_RST;
      zs         <= Z_RST;
      x0         <= X_RST;
      y0         <= Y_RST;
      z0         <= Z_RST;
      sigma      <= SIGMA_RST;
      beta       <= BETA_RST;
      rho        <= RHO_RST;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      ovf        <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            case (cfg_addr)
              3'd0:    x0    <= cfg_data;
              3'd1:    y0    <= cfg_data;
              3'd2:    z0    <= cfg_data;
              3'd3:    sigma <= cfg_data;
              3'd4:    beta  <= cfg_data;
              3'd5:    rho   <= cfg_data;
              default: ;
            endcase
          end
          // Non-blocking reads of x0/y0/z0 give init the pre-write value on a collision.
          if (init) begin
            xs         <= x0;
            ys         <= y0;
            zs         <= z0;
            step_count <= '0;
            ovf        <= 1'b0;
          end
        end
        MUL0: begin p0 <= prod_fmt; if (prod_ovf) ovf <= 1'b1; end
        MUL1: begin p1 <= prod_fmt; if (prod_ovf) ovf <= 1'b1; end
        MUL2: begin p2 <= prod_fmt; if (prod_ovf) ovf <= 1'b1; end
        MUL3: begin p3 <= prod_fmt; if (prod_ovf) ovf <= 1'b1; end
        UPD: begin
          xs         <= xs + p0;
          ys         <= ys + p1 - (ys >>> DT_SHIFT);
          zs         <= zs + p2 - p3;
          step_count <= step_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign x         = xs;
  assign y         = ys;
  assign z         = zs;
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lorenz_step_sequencer.sv
// Scoreboarded bench for lorenz_step_sequencer: a bench-side Euler model pushes the
// expected state per issued step, popped when the DUT presents the sample.
module tb_lorenz_step_sequencer;
  localparam logic [26:0] X_R = 27'(-1048576);
  localparam logic [26:0] Y_R = 27'(104857);
  localparam logic [26:0] Z_R = 27'(26214400);

  logic        clk = 1'b0;
  logic        reset = 1'b1, cfg_we = 1'b0, init = 1'b0, run = 1'b0, out_ready = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [26:0] cfg_data = '0;
  logic [26:0] x, y, z;
  logic        out_valid, busy, ovf;
  logic [31:0] step_count;

  // ovf cannot fire at DT_SHIFT=8 (one operand is always pre-shifted, capping the product
  // below 2^46), so a second instance with DT_SHIFT=0 exercises the flag.
  logic        cfg_we2 = 1'b0, init2 = 1'b0, run2 = 1'b0, rdy2 = 1'b0;
  logic [2:0]  cfg_addr2 = '0;
  logic [26:0] cfg_data2 = '0;
  logic [26:0] x2, y2, z2;
  logic        ov2, busy2, ovf2;
  logic [31:0] cnt2;

  lorenz_step_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .init(init), .run(run), .out_ready(out_ready), .x(x), .y(y), .z(z),
    .out_valid(out_valid), .busy(busy), .ovf(ovf), .step_count(step_count));

  lorenz_step_sequencer #(.WIDTH(27), .DT_SHIFT(0)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .init(init2), .run(run2), .out_ready(rdy2), .x(x2), .y(y2), .z(z2),
    .out_valid(ov2), .busy(busy2), .ovf(ovf2), .step_count(cnt2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0] x, y, z;
    logic [31:0] cnt;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic signed [26:0] mx, my, mz, mx0, my0, mz0, msig, mbeta, mrho;
  logic [31:0]        mcnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    mx = X_R; my = Y_R; mz = Z_R; mx0 = X_R; my0 = Y_R; mz0 = Z_R;
    msig = 27'(10485760); mbeta = 27'(2796202); mrho = 27'(29360128); mcnt = 0;
  endtask

  function automatic logic signed [26:0] fmul(input logic signed [26:0] a, input logic signed [26:0] b);
    longint m;
    m = longint'(a) * longint'(b);
    return 27'(m >>> 20);
  endfunction

  task automatic push_step;
    logic signed [26:0] a, b, p0, p1, p2, p3, t;
    a = msig >>> 8; b = my - mx; p0 = fmul(a, b);
    a = mrho - mz;  a = a >>> 8; p1 = fmul(a, mx);
    a = mx >>> 8;   p2 = fmul(a, my);
    a = mz >>> 8;   p3 = fmul(a, mbeta);
    t = my >>> 8;
    mx = mx + p0; my = my + p1 - t; mz = mz + p2 - p3;
    mcnt = mcnt + 1;
    sbq.push_back('{x: mx, y: my, z: mz, cnt: mcnt});
  endtask

  task automatic wait_valid(input bit second, input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      tick;
      n++;
      ok = second ? ov2 : out_valid;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; tick;
    checks++; if ({x, y, z} !== {X_R, Y_R, Z_R}) begin errors++;
      $display("FAIL reset_xyz got %0d %0d %0d", $signed(x), $signed(y), $signed(z)); end
    checks++; if ({out_valid, busy, ovf, step_count} !== 35'd0) begin errors++;
      $display("FAIL reset_flags got v%b b%b o%b cnt %0d exp all 0", out_valid, busy, ovf, step_count); end
    reset = 1'b0; tick;
    checks++; if (busy !== 1'b0 || x !== X_R) begin errors++;
      $display("FAIL reset_idle got busy %b x %0d", busy, $signed(x)); end
    model_reset();
  endtask

  task automatic test_first_step;
    exp_t e; int n; bit ok;
    out_ready = 1'b1; run = 1'b1; push_step();
    wait_valid(1'b0, 20, n, ok);
    checks++; if (!ok || n != 6) begin errors++;
      $display("FAIL first_latency got %0d cycles exp 6", n); end
    e = sbq.pop_front();
    checks++; if ({x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin errors++;
      $display("FAIL first_sb got %0d %0d %0d %0d exp %0d %0d %0d %0d", $signed(x), $signed(y),
               $signed(z), step_count, $signed(e.x), $signed(e.y), $signed(e.z), e.cnt); end
    checks++; if ($signed(x) != -1003521 || $signed(y) != 92160 || $signed(z) != 25940924 || step_count != 1) begin
      errors++; $display("FAIL first_const got %0d %0d %0d %0d exp -1003521 92160 25940924 1",
                         $signed(x), $signed(y), $signed(z), step_count); end
  endtask

  task automatic test_back_to_back;
    exp_t e; int n; bit ok;
    for (int i = 0; i < 3; i++) begin
      push_step();
      wait_valid(1'b0, 20, n, ok);
      checks++; if (!ok || n != 6) begin errors++;
        $display("FAIL b2b_period step %0d got %0d exp 6", i, n); end
      e = sbq.pop_front();
      checks++; if ({x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin errors++;
        $display("FAIL b2b_sb step %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", i, $signed(x), $signed(y),
                 $signed(z), step_count, $signed(e.x), $signed(e.y), $signed(e.z), e.cnt); end
      if (i == 2) run = 1'b0;
    end
    tick;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_idle got busy %b valid %b exp 0 0", busy, out_valid); end
  endtask

  task automatic test_stall;
    exp_t e; int n; bit ok;
    out_ready = 1'b0; run = 1'b1; push_step();
    wait_valid(1'b0, 20, n, ok);
    run = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_valid got timeout exp out_valid"); end
    e = sbq[0];
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (out_valid !== 1'b1 || {x, y, z} !== {e.x, e.y, e.z}) begin errors++;
        $display("FAIL stall_hold cycle %0d got v%b %0d %0d %0d exp v1 %0d %0d %0d", i, out_valid,
                 $signed(x), $signed(y), $signed(z), $signed(e.x), $signed(e.y), $signed(e.z)); end
    end
    out_ready = 1'b1; tick;
    e = sbq.pop_front();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || {x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin
      errors++; $display("FAIL stall_consume got v%b b%b x %0d cnt %0d exp v0 b0 x %0d cnt %0d",
                         out_valid, busy, $signed(x), step_count, $signed(e.x), e.cnt); end
  endtask

  task automatic test_run_drop;
    exp_t e; int n; bit ok; int extra;
    run = 1'b1; push_step();
    tick; tick;
    run = 1'b0;
    wait_valid(1'b0, 20, n, ok);
    checks++; if (!ok || n != 4) begin errors++;
      $display("FAIL drop_finish got %0d cycles exp 4", n); end
    e = sbq.pop_front();
    checks++; if ({x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin errors++;
      $display("FAIL drop_sb got %0d cnt %0d exp %0d cnt %0d", $signed(x), step_count, $signed(e.x), e.cnt); end
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got busy %b exp 0", busy); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick; if (out_valid || busy) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL drop_extra got %0d active cycles exp 0", extra); end
  endtask

  task automatic test_cfg_init;
    exp_t e; int n; bit ok;
    run = 1'b1; tick;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = '0; init = 1'b1;
    push_step();
    tick; tick;
    cfg_we = 1'b0; init = 1'b0; run = 1'b0;
    wait_valid(1'b0, 20, n, ok);
    e = sbq.pop_front();
    checks++; if (!ok || {x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin errors++;
      $display("FAIL busy_cfg_sb got %0d cnt %0d exp %0d cnt %0d", $signed(x), step_count, $signed(e.x), e.cnt); end
    tick;
    init = 1'b1; tick; init = 1'b0;
    mx = mx0; my = my0; mz = mz0; mcnt = 0;
    checks++; if (x !== mx || step_count !== 0) begin errors++;
      $display("FAIL busy_cfg_ignored got x %0d cnt %0d exp x %0d cnt 0", $signed(x), step_count, mx); end
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = '0; tick; cfg_we = 1'b0;
    init = 1'b1; tick; init = 1'b0;
    mx0 = '0; mx = mx0;
    checks++; if ({x, y, z, step_count} !== {mx, my, mz, 32'd0}) begin errors++;
      $display("FAIL idle_cfg_init got %0d %0d %0d cnt %0d exp %0d %0d %0d 0", $signed(x), $signed(y),
               $signed(z), step_count, mx, my, mz); end
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 27'd524288; init = 1'b1; tick;
    cfg_we = 1'b0; init = 1'b0;
    checks++; if (y !== Y_R) begin errors++;
      $display("FAIL cfg_init_collide got y %0d exp %0d", $signed(y), Y_R); end
    init = 1'b1; run = 1'b1; tick; init = 1'b0; run = 1'b0;
    my0 = 27'd524288; my = my0;
    checks++; if (y !== my || busy !== 1'b0) begin errors++;
      $display("FAIL init_over_run got y %0d busy %b exp y %0d busy 0", $signed(y), busy, my); end
  endtask

  task automatic test_reset_mid;
    exp_t e; int n; bit ok; int extra;
    run = 1'b1; out_ready = 1'b1; push_step();
    wait_valid(1'b0, 20, n, ok);
    e = sbq.pop_front();
    checks++; if (!ok || {x, y, z, step_count} !== {e.x, e.y, e.z, e.cnt}) begin errors++;
      $display("FAIL pre_abort_sb got %0d %0d %0d cnt %0d exp %0d %0d %0d %0d", $signed(x), $signed(y),
               $signed(z), step_count, $signed(e.x), $signed(e.y), $signed(e.z), e.cnt); end
    tick; tick; tick; tick;
    reset = 1'b1; run = 1'b0; tick;
    checks++; if ({busy, out_valid, step_count} !== 34'd0 || {x, y, z} !== {X_R, Y_R, Z_R}) begin errors++;
      $display("FAIL abort_reset got b%b v%b cnt %0d x %0d y %0d z %0d", busy, out_valid, step_count,
               $signed(x), $signed(y), $signed(z)); end
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin tick; if (out_valid) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL abort_no_emit got %0d valids exp 0", extra); end
    model_reset();
    init = 1'b1; tick; init = 1'b0;
    checks++; if ({x, y, z} !== {mx0, my0, mz0}) begin errors++;
      $display("FAIL abort_seeds got %0d %0d %0d exp %0d %0d %0d", $signed(x), $signed(y), $signed(z), mx0, my0, mz0); end
  endtask

  task automatic test_ovf;
    int n; bit ok;
    cfg_we2 = 1'b1;
    cfg_addr2 = 3'd3; cfg_data2 = 27'h3FFFFFF; tick;
    cfg_addr2 = 3'd0; cfg_data2 = 27'(-16777216); tick;
    cfg_addr2 = 3'd1; cfg_data2 = 27'(16777216); tick;
    cfg_we2 = 1'b0; init2 = 1'b1; tick; init2 = 1'b0;
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_init got %b exp 0", ovf2); end
    run2 = 1'b1; rdy2 = 1'b1;
    wait_valid(1'b1, 20, n, ok);
    checks++; if (!ok || ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf2); end
    wait_valid(1'b1, 20, n, ok);
    run2 = 1'b0;
    checks++; if (!ok || ovf2 !== 1'b1 || cnt2 !== 2) begin errors++;
      $display("FAIL ovf_sticky got %b cnt %0d exp 1 cnt 2", ovf2, cnt2); end
    tick; tick;
    checks++; if (ovf2 !== 1'b1 || busy2 !== 1'b0) begin errors++;
      $display("FAIL ovf_idle got ovf %b busy %b exp 1 0", ovf2, busy2); end
    init2 = 1'b1; tick; init2 = 1'b0;
    checks++; if (ovf2 !== 1'b0 || cnt2 !== 0) begin errors++;
      $display("FAIL ovf_clear got ovf %b cnt %0d exp 0 0", ovf2, cnt2); end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_back_to_back();
    test_stall();
    test_run_drop();
    test_cfg_init();
    test_reset_mid();
    test_ovf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
